ts_packet_scheduler: RTL and testbench

Round-robin packet scheduler for the four-input TS muxer, running on the system clock. It watches the per-channel "full packet ready" flags from the four input reclock/prepare stages and grants exactly one whole 188-byte packet at a time. It issues the one-shot packet request to the granted channel, drives the data-path select, and generates D_VALID/P_SYNC framing for the output FIFO write side. Channels are masked by an enable vector from the SPI register file. Scheduling halts while the output FIFO reports almost-full.

---
 rtl/ts_packet_scheduler.sv | 125 ++++++++++++
 tb/tb_ts_packet_scheduler.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ts_packet_scheduler.sv
// Round-robin scheduler for the four-input TS muxer: grants one whole packet at a
// time and frames the output FIFO write side with D_VALID_OUT/P_SYNC_OUT.
module ts_packet_scheduler #(
    parameter int PKT_LEN    = 188,
    parameter int RD_LATENCY = 1,
    parameter int GAP_CYCLES = 2
) (
    input  logic        SYS_CLK,
    input  logic        RST,
    input  logic [3:0]  CH_ENABLE,
    input  logic [3:0]  GOT_FULL_PACKET,
    input  logic        FIFO_ALMOST_FULL,
    output logic [3:0]  GIVE_ME_ONE_PACKET,
    output logic [1:0]  SEL,
    output logic        D_VALID_OUT,
    output logic        P_SYNC_OUT,
    output logic        BUSY,
    output logic [15:0] PKT_COUNT
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_READ,
        ST_GAP
    } state_t;

    localparam logic [7:0] LAST_BYTE = 8'(PKT_LEN - 1);
    localparam logic [3:0] WAIT_LOAD = 4'(RD_LATENCY - 1);
    localparam logic [3:0] GAP_LOAD  = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t     state;
    logic [1:0] last;
    logic [3:0] phase_cnt;
    logic [7:0] byte_cnt;

    logic [3:0] elig;
    logic       grant_ok;
    logic [1:0] winner;
    logic [1:0] cand;

    assign elig     = GOT_FULL_PACKET & CH_ENABLE;
    assign grant_ok = (elig != 4'b0000) && !FIFO_ALMOST_FULL;

    // NOTE: every variable gets a default before the loop so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        winner = last;
        cand   = last;
        // Scan farthest offset first so the nearest eligible channel after LAST wins.
        for (int k = 4; k >= 1; k--) begin
            cand = last + 2'(k);
            if (elig[cand]) begin
                winner = cand;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge SYS_CLK or negedge RST) begin
        if (!RST) begin
            state              <= ST_IDLE;
            last               <= 2'd3;
            phase_cnt          <= '0;
            byte_cnt           <= '0;
            GIVE_ME_ONE_PACKET <= '0;
            SEL                <= '0;
            D_VALID_OUT        <= 1'b0;
            P_SYNC_OUT         <= 1'b0;
            BUSY               <= 1'b0;
            PKT_COUNT          <= '0;
        end else begin
            GIVE_ME_ONE_PACKET <= '0;
            P_SYNC_OUT         <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_ok) begin
                        GIVE_ME_ONE_PACKET <= 4'b0001 << winner;
                        SEL                <= winner;
                        last               <= winner;
                        PKT_COUNT          <= PKT_COUNT + 16'd1;
                        BUSY               <= 1'b1;
                        phase_cnt          <= WAIT_LOAD;
                        state              <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (phase_cnt == 4'd0) begin
                        state       <= ST_READ;
                        D_VALID_OUT <= 1'b1;
                        P_SYNC_OUT  <= 1'b1;
                        byte_cnt    <= '0;
                    end else begin
                        phase_cnt <= phase_cnt - 4'd1;
                    end
                end
                ST_READ: begin
                    if (byte_cnt == LAST_BYTE) begin
                        D_VALID_OUT <= 1'b0;
                        if (GAP_CYCLES == 0) begin
                            state <= ST_IDLE;
                            BUSY  <= 1'b0;
                        end else begin
                            state     <= ST_GAP;
                            phase_cnt <= GAP_LOAD;
                        end
                    end else begin
                        byte_cnt <= byte_cnt + 8'd1;
                    end
                end
                ST_GAP: begin
                    if (phase_cnt == 4'd0) begin
                        state <= ST_IDLE;
                        BUSY  <= 1'b0;
                    end else begin
                        phase_cnt <= phase_cnt - 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ts_packet_scheduler.sv
// Scoreboard bench for ts_packet_scheduler: a packet-level model predicts grants
// and the framing window of each packet; a monitor compares at every falling edge.
module tb_ts_packet_scheduler;

    localparam int PKT_LEN    = 188;
    localparam int RD_LATENCY = 1;
    localparam int GAP_CYCLES = 2;
    localparam int PERIOD     = 1 + RD_LATENCY + PKT_LEN + GAP_CYCLES;

    logic        SYS_CLK;
    logic        RST;
    logic [3:0]  CH_ENABLE;
    logic [3:0]  GOT_FULL_PACKET;
    logic        FIFO_ALMOST_FULL;
    logic [3:0]  GIVE_ME_ONE_PACKET;
    logic [1:0]  SEL;
    logic        D_VALID_OUT;
    logic        P_SYNC_OUT;
    logic        BUSY;
    logic [15:0] PKT_COUNT;

    ts_packet_scheduler #(
        .PKT_LEN   (PKT_LEN),
        .RD_LATENCY(RD_LATENCY),
        .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .SYS_CLK           (SYS_CLK),
        .RST               (RST),
        .CH_ENABLE         (CH_ENABLE),
        .GOT_FULL_PACKET   (GOT_FULL_PACKET),
        .FIFO_ALMOST_FULL  (FIFO_ALMOST_FULL),
        .GIVE_ME_ONE_PACKET(GIVE_ME_ONE_PACKET),
        .SEL               (SEL),
        .D_VALID_OUT       (D_VALID_OUT),
        .P_SYNC_OUT        (P_SYNC_OUT),
        .BUSY              (BUSY),
        .PKT_COUNT         (PKT_COUNT)
    );

    initial SYS_CLK = 1'b0;
    always #5 SYS_CLK = ~SYS_CLK;

    typedef struct {
        int ch;
        int count;
    } grant_t;

    grant_t exp_q[$];
    int     obs_log[$];
    int     checks   = 0;
    int     failures = 0;
    int     edge_n   = 0;
    int     m_last   = 3;
    int     m_count  = 0;
    int     m_g      = -100000;
    int     m_ch     = 0;
    bit     started  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", name, act, exp, edge_n, $time);
        end
    endtask

    // Packet-level model: a grant may only happen a full packet period after the
    // previous one, and goes to the nearest eligible channel after the last winner.
    always @(posedge SYS_CLK or negedge RST) begin
        if (!RST) begin
            m_last  = 3;
            m_count = 0;
            m_g     = -100000;
            m_ch    = 0;
            exp_q.delete();
        end else begin
            edge_n++;
            if (edge_n >= m_g + PERIOD && (GOT_FULL_PACKET & CH_ENABLE) != 4'b0000
                && !FIFO_ALMOST_FULL) begin
                for (int k = 1; k <= 4; k++) begin
                    int c;
                    c = (m_last + k) % 4;
                    if ((GOT_FULL_PACKET[c] & CH_ENABLE[c]) && edge_n != m_g) begin
                        m_g     = edge_n;
                        m_ch    = c;
                        m_last  = c;
                        m_count = (m_count + 1) % 65536;
                        exp_q.push_back('{c, m_count});
                    end
                end
            end
        end
    end

    // Monitor: pops the scoreboard on each observed grant and checks framing.
    always @(negedge SYS_CLK) begin
        if (RST && started) begin
            int          d;
            logic [31:0] act_v;
            logic [31:0] exp_v;
            if (GIVE_ME_ONE_PACKET != 4'b0000) begin
                int idx;
                grant_t g;
                idx = 0;
                for (int i = 0; i < 4; i++) if (GIVE_ME_ONE_PACKET[i]) idx = i;
                obs_log.push_back(idx);
                if (exp_q.size() == 0) begin
                    check("unexpected_grant", {28'd0, GIVE_ME_ONE_PACKET}, 32'd0);
                end else begin
                    g = exp_q.pop_front();
                    check("grant_ch", {28'd0, GIVE_ME_ONE_PACKET}, 32'd1 << g.ch);
                    check("grant_count", {16'd0, PKT_COUNT}, g.count);
                end
            end else if (exp_q.size() != 0) begin
                grant_t g;
                g = exp_q.pop_front();
                check("missed_grant", {28'd0, GIVE_ME_ONE_PACKET}, 32'd1 << g.ch);
            end
            d     = edge_n - m_g;
            act_v = {7'd0, GIVE_ME_ONE_PACKET, SEL, D_VALID_OUT, P_SYNC_OUT, BUSY, PKT_COUNT};
            exp_v = {7'd0,
                     (d == 0) ? (4'b0001 << m_ch) : 4'b0000,
                     2'(m_ch),
                     (d >= RD_LATENCY && d < RD_LATENCY + PKT_LEN),
                     (d == RD_LATENCY),
                     (d >= 0 && d < RD_LATENCY + PKT_LEN + GAP_CYCLES),
                     16'(m_count)};
            check("frame", act_v, exp_v);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge SYS_CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b0;
        tick(2);
        RST = 1'b1;
        started = 1'b1;
        obs_log.delete();
    endtask

    initial begin
        RST              = 1'b0;
        CH_ENABLE        = 4'b0000;
        GOT_FULL_PACKET  = 4'b0000;
        FIFO_ALMOST_FULL = 1'b0;
        tick(1);
        check("reset_outputs", {7'd0, GIVE_ME_ONE_PACKET, SEL, D_VALID_OUT, P_SYNC_OUT, BUSY, PKT_COUNT}, 32'd0);
        do_reset();

        // Single packet from channel 2.
        CH_ENABLE       = 4'b1111;
        GOT_FULL_PACKET = 4'b0100;
        tick(1);
        check("p1_give", {28'd0, GIVE_ME_ONE_PACKET}, 32'h4);
        GOT_FULL_PACKET = 4'b0000;
        tick(PERIOD);
        check("p1_count", {16'd0, PKT_COUNT}, 32'd1);
        check("p1_busy", {31'd0, BUSY}, 32'd0);
        check("p1_sel_held", {30'd0, SEL}, 32'd2);

        // All channels eligible: strict rotation from channel 0.
        do_reset();
        GOT_FULL_PACKET = 4'b1111;
        tick(8 * PERIOD - 10);
        check("p2_grants", obs_log.size(), 32'd8);
        for (int i = 0; i < obs_log.size() && i < 8; i++) check("p2_order", obs_log[i], i % 4);
        check("p2_count", {16'd0, PKT_COUNT}, 32'd8);
        GOT_FULL_PACKET = 4'b0000;
        tick(PERIOD);

        // Mask 1010: only channels 1 and 3 alternate.
        do_reset();
        CH_ENABLE       = 4'b1010;
        GOT_FULL_PACKET = 4'b1111;
        tick(4 * PERIOD - 10);
        check("p3_grants", obs_log.size(), 32'd4);
        for (int i = 0; i < obs_log.size() && i < 4; i++) check("p3_order", obs_log[i], (i % 2 == 0) ? 1 : 3);
        GOT_FULL_PACKET = 4'b0000;
        CH_ENABLE       = 4'b1111;
        tick(PERIOD);

        // Almost-full raised during READ: packet completes, then no grant until cleared.
        do_reset();
        GOT_FULL_PACKET = 4'b0001;
        tick(1);
        tick(50);
        FIFO_ALMOST_FULL = 1'b1;
        GOT_FULL_PACKET  = 4'b1111;
        tick(400);
        check("p4_count", {16'd0, PKT_COUNT}, 32'd1);
        check("p4_idle", {31'd0, BUSY}, 32'd0);
        FIFO_ALMOST_FULL = 1'b0;
        tick(1);
        check("p4_grant", {28'd0, GIVE_ME_ONE_PACKET}, 32'h2);
        GOT_FULL_PACKET = 4'b0000;
        tick(PERIOD);

        // Asynchronous reset at byte 100 of a packet.
        do_reset();
        GOT_FULL_PACKET = 4'b0010;
        tick(1);
        tick(RD_LATENCY + 100);
        check("p5_mid_dv", {31'd0, D_VALID_OUT}, 32'd1);
        #2;
        RST = 1'b0;
        #1;
        check("p5_async_rst", {7'd0, GIVE_ME_ONE_PACKET, SEL, D_VALID_OUT, P_SYNC_OUT, BUSY, PKT_COUNT}, 32'd0);
        @(posedge SYS_CLK);
        #1;
        RST             = 1'b1;
        GOT_FULL_PACKET = 4'b1111;
        tick(1);
        check("p5_first_grant", {28'd0, GIVE_ME_ONE_PACKET}, 32'h1);
        GOT_FULL_PACKET = 4'b0000;
        tick(PERIOD);

        // Inputs changed mid-READ do not disturb the packet; new mask applies next time.
        do_reset();
        GOT_FULL_PACKET = 4'b0100;
        tick(1);
        tick(60);
        GOT_FULL_PACKET = 4'b0000;
        CH_ENABLE       = 4'b0001;
        tick(60);
        check("p6_sel", {30'd0, SEL}, 32'd2);
        check("p6_dv", {31'd0, D_VALID_OUT}, 32'd1);
        GOT_FULL_PACKET = 4'b1111;
        tick(PERIOD);
        check("p6_grants", obs_log.size(), 32'd2);
        if (obs_log.size() >= 2) check("p6_next", obs_log[1], 32'd0);
        GOT_FULL_PACKET = 4'b0000;
        CH_ENABLE       = 4'b1111;
        tick(PERIOD);

        // Randomized traffic, mask and back-pressure.
        do_reset();
        repeat (4000) begin
            tick(1);
            if ($urandom_range(0, 7) == 0)  GOT_FULL_PACKET  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 63) == 0) CH_ENABLE        = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) FIFO_ALMOST_FULL = ($urandom_range(0, 3) == 0);
        end
        GOT_FULL_PACKET  = 4'b0000;
        FIFO_ALMOST_FULL = 1'b0;
        tick(PERIOD);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
